// File: rtl/adder_cla_multicycle.sv
// Multi-cycle add/subtract: one CHUNK-bit carry-lookahead slice per clock, LSB first,
// with the inter-slice carry held in a register between cycles.

module cla_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);
  logic [CHUNK-1:0] g, p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a | b;

  // Each carry is the flat sum-of-products over generate/propagate terms,
  // so no carry depends on the previous bit's carry.
  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      term = c_in;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign sum   = a ^ b ^ c[CHUNK-1:0];
  assign c_out = c[CHUNK];
endmodule

module adder_cla_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic             ctrl_sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_result,
  output logic             data_cout,
  output logic             data_ovf,
  output logic             data_busy,
  output logic             data_resultRDY
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state, state_nxt;
  logic [KW-1:0]               k;
  logic [NCH-1:0][CHUNK-1:0]   a_sl, b_sl, res_q;
  logic                        carry;
  logic [CHUNK-1:0]            sl_sum;
  logic                        sl_cout;
  logic                        accept, last;

  assign accept      = ctrl_start && (state != RUN);
  assign last        = (k == KW'(NCH - 1));
  assign data_busy   = (state == RUN);
  assign data_result = res_q;

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (a_sl[k]),
    .b     (b_sl[k]),
    .c_in  (carry),
    .sum   (sl_sum),
    .c_out (sl_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k              <= '0;
      a_sl           <= '0;
      b_sl           <= '0;
      carry          <= 1'b0;
      res_q          <= '0;
      data_cout      <= 1'b0;
      data_ovf       <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1; the caller's cin plays no part in it.
      a_sl           <= data_a;
      b_sl           <= ctrl_sub ? ~data_b : data_b;
      carry          <= ctrl_sub ? 1'b1 : cin;
      k              <= '0;
      res_q          <= '0;
      data_cout      <= 1'b0;
      data_ovf       <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (state == RUN) begin
      res_q[k]       <= sl_sum;
      carry          <= sl_cout;
      k              <= last ? '0 : k + KW'(1);
      data_resultRDY <= last;
      if (last) begin
        data_cout <= sl_cout;
        data_ovf  <= (a_sl[NCH-1][CHUNK-1] == b_sl[NCH-1][CHUNK-1]) &&
                     (sl_sum[CHUNK-1] != a_sl[NCH-1][CHUNK-1]);
      end
    end else begin
      k              <= '0;
      data_resultRDY <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_cla_multicycle.sv
// Directed bench for adder_cla_multicycle: arithmetic reference model checked every
// cycle, plus literal expectations for each directed vector.

module tb_adder_cla_multicycle;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ctrl_start = 1'b1;
  logic             ctrl_sub = 1'b0;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] data_a = 32'hDEADBEEF;
  logic [WIDTH-1:0] data_b = 32'h12345678;
  logic [WIDTH-1:0] data_result;
  logic             data_cout, data_ovf, data_busy, data_resultRDY;

  adder_cla_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_sub       (ctrl_sub),
    .cin            (cin),
    .data_a         (data_a),
    .data_b         (data_b),
    .data_result    (data_result),
    .data_cout      (data_cout),
    .data_ovf       (data_ovf),
    .data_busy      (data_busy),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] low_mask(input int n);
    logic [63:0] m;
    m = (64'd1 << (n * CHUNK)) - 64'd1;
    return m[WIDTH-1:0];
  endfunction

  // Reference model: full-width sum computed once on accept, revealed one slice per edge.
  logic             m_busy = 1'b0, m_rdy = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [WIDTH-1:0] m_res = '0, m_be;
  logic [WIDTH:0]   m_full;
  logic             m_c, m_ovf_pend;
  longint           m_ssum;
  int               m_n = 0;
  logic             chk_en = 1'b0;

  always @(posedge clock) begin
    chk_en = 1'b1;
    if (reset) begin
      m_busy = 0; m_rdy = 0; m_cout = 0; m_ovf = 0; m_res = '0; m_n = 0;
    end else if (ctrl_start && !m_busy) begin
      m_be       = ctrl_sub ? ~data_b : data_b;
      m_c        = ctrl_sub ? 1'b1 : cin;
      m_full     = {1'b0, data_a} + {1'b0, m_be} + {{WIDTH{1'b0}}, m_c};
      m_ssum     = longint'($signed(data_a)) + longint'($signed(m_be)) + longint'(m_c);
      m_ovf_pend = (m_ssum > 64'sd2147483647) || (m_ssum < -64'sd2147483648);
      m_res = '0; m_cout = 0; m_ovf = 0; m_rdy = 0; m_busy = 1; m_n = 0;
    end else if (m_busy) begin
      m_n++;
      m_res = m_full[WIDTH-1:0] & low_mask(m_n);
      if (m_n == NCH) begin
        m_busy = 0; m_rdy = 1; m_cout = m_full[WIDTH]; m_ovf = m_ovf_pend;
      end
    end else begin
      m_rdy = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_busy",   data_busy,      m_busy);
      chk("cyc_rdy",    data_resultRDY, m_rdy);
      chk("cyc_result", data_result,    m_res);
      chk("cyc_cout",   data_cout,      m_cout);
      chk("cyc_ovf",    data_ovf,       m_ovf);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Start must already be asserted; waits for the pulse, checking latency and busy length.
  task automatic wait_rdy(input string name, input logic [WIDTH-1:0] er, input logic ec, input logic eo);
    int   n, nbusy;
    logic seen;
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (data_busy) nbusy++;
      if (data_resultRDY) begin
        seen = 1;
        chk({name, "_result"}, data_result, er);
        chk({name, "_cout"},   data_cout,   ec);
        chk({name, "_ovf"},    data_ovf,    eo);
      end
      #1;
      ctrl_start = 1'b0;
    end
    chk({name, "_seen"},  seen,  1);
    chk({name, "_lat"},   n,     NCH + 1);
    chk({name, "_busyn"}, nbusy, NCH);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input logic c,
                        input logic [WIDTH-1:0] er, input logic ec, input logic eo);
    ctrl_start = 1'b1; ctrl_sub = sub; cin = c; data_a = a; data_b = b;
    wait_rdy(name, er, ec, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two edges with start high.
    @(negedge clock);
    @(negedge clock);
    chk("rst_result", data_result,    0);
    chk("rst_busy",   data_busy,      0);
    chk("rst_rdy",    data_resultRDY, 0);
    chk("rst_cout",   data_cout,      0);
    #1;
    reset = 1'b0; ctrl_start = 1'b0;
    step();

    run_op("add_ff_1",    32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0);
    step();
    run_op("add_cin",     32'h000000FF, 32'h00000001, 0, 1, 32'h00000101, 0, 0);
    step();
    run_op("add_wrap",    32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0);
    step();
    run_op("add_ovf",     32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1);
    step();
    run_op("sub_5_7",     32'h00000005, 32'h00000007, 1, 0, 32'hFFFFFFFE, 0, 0);
    step();
    run_op("sub_ovf",     32'h80000000, 32'h00000001, 1, 1, 32'h7FFFFFFF, 1, 1);
    step();

    // Starts during RUN are ignored; start on the pulse cycle is accepted.
    ctrl_start = 1'b1; ctrl_sub = 0; cin = 0;
    data_a = 32'h11111111; data_b = 32'h22222222;
    for (int i = 1; i <= NCH + 1; i++) begin
      @(negedge clock);
      if (i <= NCH) chk("ign_busy", data_busy, 1);
      else begin
        chk("ign_rdy",    data_resultRDY, 1);
        chk("ign_result", data_result,    32'h33333333);
      end
      #1;
      if (i < NCH) begin
        ctrl_start = 1'b1; ctrl_sub = 1; cin = 1;
        data_a = 32'hAAAAAAAA; data_b = 32'h0F0F0F0F;
      end else if (i == NCH) begin
        ctrl_start = 1'b0;
      end else begin
        ctrl_start = 1'b1; ctrl_sub = 0; cin = 0;
        data_a = 32'h00000010; data_b = 32'h00000020;
      end
    end
    wait_rdy("b2b", 32'h00000030, 0, 0);
    step();

    // Reset in the middle of a RUN.
    ctrl_start = 1'b1; ctrl_sub = 0; cin = 0;
    data_a = 32'h12345678; data_b = 32'h00000001;
    step();
    ctrl_start = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy",   data_busy,      0);
    chk("mid_rst_result", data_result,    0);
    chk("mid_rst_rdy",    data_resultRDY, 0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NCH + 2; i++) begin
      @(negedge clock);
      chk("mid_rst_nordy", data_resultRDY, 0);
    end
    #1;
    run_op("add_3_4", 32'h00000003, 32'h00000004, 0, 0, 32'h00000007, 0, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
